// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 timing defaults and decode helper for the VGA timing core
// and the pixel/colour stage.
package vga_sync_gen_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_DISP_DEF  = 640;
    localparam int unsigned H_FP_DEF    = 16;
    localparam int unsigned H_SYNC_DEF  = 96;
    localparam int unsigned H_BP_DEF    = 48;
    localparam int unsigned H_TOTAL_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_DISP_DEF  = 480;
    localparam int unsigned V_FP_DEF    = 10;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BP_DEF    = 33;
    localparam int unsigned V_TOTAL_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // True when cnt lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input int unsigned      lo,
                                       input int unsigned      len);
        return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate strobe: divides clk by TICK_DIV and emits a registered one-clk
// p_tick, first asserted TICK_DIV clks after reset is released.
module vga_pixel_tick #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned TW = $clog2(TICK_DIV);

    if (TICK_DIV < 2 || (TICK_DIV & (TICK_DIV - 1)) != 0) begin : g_bad_div
        $error("vga_pixel_tick: TICK_DIV must be a power of two >= 2");
    end

    logic [TW-1:0] tick_cnt;

    // Power-of-two divider: the counter wraps naturally at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            p_tick   <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
            p_tick   <= (tick_cnt == TW'(TICK_DIV - 1));
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing core: pixel tick, horizontal/vertical counters and registered
// hsync/vsync/video_on/frame_start, all aligned with pixel_x/pixel_y.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned H_DISP   = H_DISP_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_DISP   = V_DISP_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned TICK_DIV = 4,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    vga_pixel_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_pixel_tick (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;

    always_comb begin
        x_next = pixel_x + CNT_W'(1);
        y_next = pixel_y;
        if (pixel_x == H_LAST) begin
            x_next = '0;
            y_next = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
        end
    end

    // Sync/blank flags decode the next-count values so they load on the same
    // edge as the counters and never lag pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (p_tick) begin
                pixel_x     <= x_next;
                pixel_y     <= y_next;
                video_on    <= (32'(x_next) < H_DISP) && (32'(y_next) < V_DISP);
                hsync       <= in_window(x_next, H_DISP + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync       <= in_window(y_next, V_DISP + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
                frame_start <= (x_next == '0) && (y_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen: 800-pixel lines at the default
// horizontal timing with a 13-line frame so a whole frame fits in the run.
module tb_vga_sync_gen;

    localparam int unsigned H_TOT = 800;
    localparam int unsigned V_TOT = 13;   // 6 visible, FP 2, sync 2 (lines 8..9), BP 3

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    vga_sync_gen #(
        .H_DISP  (640),
        .H_FP    (16),
        .H_SYNC  (96),
        .H_BP    (48),
        .V_DISP  (6),
        .V_FP    (2),
        .V_SYNC  (2),
        .V_BP    (3),
        .TICK_DIV(4),
        .SYNC_POL(1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned ticks    = 0;
    int unsigned vs_low   = 0;
    int unsigned fs_count = 0;
    logic        align_en = 1'b0;
    logic [9:0]  exp_x    = '0;
    logic [9:0]  exp_y    = '0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] exp;   // {hsync, vsync, video_on, frame_start}
    } vec_t;

    vec_t vecs[20];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)",
                     name, act, expv, pixel_x, pixel_y, $time);
        end
    endtask

    function automatic logic [2:0] ref_dec(input logic [9:0] x, input logic [9:0] y);
        logic hs, vs, vid;
        hs  = !(x >= 10'd656 && x <= 10'd751);
        vs  = !(y >= 10'd8 && y <= 10'd9);
        vid = (x < 10'd640) && (y < 10'd6);
        return {hs, vs, vid};
    endfunction

    always @(negedge clk) begin
        if (align_en) begin
            check("align", 32'({hsync, vsync, video_on}), 32'(ref_dec(pixel_x, pixel_y)));
            if (frame_start) begin
                fs_count++;
                check("fs_pos", 32'({pixel_x, pixel_y}), 32'(0));
            end
        end
    end

    // Advance one pixel tick and compare the counters with an independent model.
    task automatic adv_tick();
        int unsigned n = 0;
        @(negedge clk);
        while (!p_tick && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!p_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: p_tick 0 expected 1 within 9 clks");
            return;
        end
        @(posedge clk);
        #1;
        if (32'(exp_x) == H_TOT - 1) begin
            exp_x = '0;
            exp_y = (32'(exp_y) == V_TOT - 1) ? 10'd0 : exp_y + 10'd1;
        end else begin
            exp_x = exp_x + 10'd1;
        end
        check("pos", 32'({pixel_x, pixel_y}), 32'({exp_x, exp_y}));
        ticks++;
        if (!vsync) vs_low++;
    endtask

    task automatic run_to(input logic [9:0] tx, input logic [9:0] ty);
        int unsigned n = 0;
        while (!(pixel_x == tx && pixel_y == ty) && n < 11000) begin
            adv_tick();
            n++;
        end
        if (!(pixel_x == tx && pixel_y == ty)) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: at (%0d,%0d) expected (%0d,%0d) within 11000 ticks",
                     pixel_x, pixel_y, tx, ty);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned hs_low;
        int unsigned first_off;
        logic        seen_off;

        vecs[0]  = '{10'd639, 10'd2,  4'b1110};
        vecs[1]  = '{10'd640, 10'd2,  4'b1100};
        vecs[2]  = '{10'd655, 10'd2,  4'b1100};
        vecs[3]  = '{10'd656, 10'd2,  4'b0100};
        vecs[4]  = '{10'd751, 10'd2,  4'b0100};
        vecs[5]  = '{10'd752, 10'd2,  4'b1100};
        vecs[6]  = '{10'd799, 10'd2,  4'b1100};
        vecs[7]  = '{10'd0,   10'd3,  4'b1110};
        vecs[8]  = '{10'd639, 10'd5,  4'b1110};
        vecs[9]  = '{10'd640, 10'd5,  4'b1100};
        vecs[10] = '{10'd799, 10'd5,  4'b1100};
        vecs[11] = '{10'd0,   10'd6,  4'b1100};
        vecs[12] = '{10'd639, 10'd7,  4'b1100};
        vecs[13] = '{10'd0,   10'd8,  4'b1000};
        vecs[14] = '{10'd700, 10'd9,  4'b0000};
        vecs[15] = '{10'd799, 10'd9,  4'b1000};
        vecs[16] = '{10'd0,   10'd10, 4'b1100};
        vecs[17] = '{10'd799, 10'd12, 4'b1100};
        vecs[18] = '{10'd0,   10'd0,  4'b1111};
        vecs[19] = '{10'd1,   10'd0,  4'b1110};

        // T1: reset held 3 clks, then first p_tick on the 4th clk after release
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_ptick", 32'(p_tick), 32'(0));
        end
        @(negedge clk);
        align_en = 1'b1;
        check("rst_pos", 32'({pixel_x, pixel_y}), 32'(0));
        check("rst_flags", 32'({hsync, vsync, video_on, frame_start}), 32'(4'b1110));
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("first_tick", 32'(p_tick), 32'(i == 4));
            check("hold_pos", 32'({pixel_x, pixel_y}), 32'(0));
        end
        exp_x    = '0;
        exp_y    = '0;
        ticks    = 0;
        vs_low   = 0;
        fs_count = 0;
        adv_tick();

        // T2: one full line starting at (0,1)
        run_to(10'd0, 10'd1);
        c0        = cyc;
        hs_low    = 0;
        first_off = 0;
        seen_off  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            adv_tick();
            if (!hsync) hs_low++;
            if (!video_on && !seen_off) begin
                seen_off  = 1'b1;
                first_off = 32'(pixel_x);
            end
        end
        check("line_clks", cyc - c0, 3200);
        check("hsync_ticks", hs_low, 96);
        check("video_off_x", first_off, 640);
        check("line_end", 32'({pixel_x, pixel_y}), 32'({10'd0, 10'd2}));

        // T3/T5: walk the rest of the frame through the boundary positions
        for (int i = 0; i < 20; i++) begin
            run_to(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d", i), 32'({hsync, vsync, video_on, frame_start}),
                  32'(vecs[i].exp));
        end
        check("frame_ticks", ticks, 10401);
        check("vsync_ticks", vs_low, 1600);
        check("fs_count", fs_count, 1);

        // T4: reset for one clk at (700,2), landing on a p_tick edge
        run_to(10'd700, 10'd2);
        begin
            int unsigned n = 0;
            @(negedge clk);
            while (!p_tick && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t4_pos", 32'({pixel_x, pixel_y}), 32'(0));
        check("t4_flags", 32'({hsync, vsync, video_on, frame_start, p_tick}), 32'(5'b11100));
        @(negedge clk);
        reset = 1'b0;
        exp_x = '0;
        exp_y = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("t4_tick", 32'(p_tick), 32'(i == 4));
        end
        adv_tick();
        adv_tick();
        check("t4_fs_count", fs_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
